term_screen_buffer: RTL



---
 rtl/term_screen_buffer.sv | 370 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/term_screen_buffer.sv
// -----------------------------------------------------------------------------
// term_screen_buffer
//
// Character-grid terminal memory fed by the keyboard/lambda editor. Character
// codes and command edges are queued in a small event FIFO, then applied one
// per cycle to a ring of HIST_LINES text lines of COLS characters each. A
// registered read port serves the VGA text renderer with the current view,
// which follows the cursor unless the user has paged up into history.
//
// After reset the whole ring is wiped to code_null (INIT); a breakline wipes
// the new cursor line (CLEAR). Neither wipe pops the FIFO, so characters
// typed meanwhile wait in the queue instead of being lost.
//
// Build option:
//   TERM_AUTOWRAP_EN  defined   : a character written in the last column is
//                                 followed by an implicit breakline.
//                     undefined : the cursor sticks in the last column and
//                                 later characters overwrite that cell.
//
// Ports:
//   clk_25mhz  in   sole clock
//   reset      in   synchronous, active-low reset
//   ch_append  in   character code; 0 (null) and 63 (none) carry no character
//   cmd        in   bit0 busy, bit1 pgup, bit2 pgdown, bit3 backspace,
//                   bit4 breakline (bits 1..4 act on rising edges)
//   rd_row     in   visible row to read, 0 = top
//   rd_col     in   column to read
//   rd_code    out  registered code at (rd_row, rd_col) of the previous cycle
//   cur_col    out  cursor column
//   cur_line   out  cursor line in the history ring
//   busy       out  cmd[0] delayed by one cycle
//   ready      out  power-up wipe finished
//   overflow   out  sticky; an event was dropped
// -----------------------------------------------------------------------------
module term_screen_buffer #(
   parameter int COLS       = 32,
   parameter int HIST_LINES = 32,
   parameter int ROWS       = 15,
   parameter int FIFO_DEPTH = 16,
   localparam int COL_W     = $clog2(COLS),
   localparam int LINE_W    = $clog2(HIST_LINES)
) (
   input  logic              clk_25mhz,
   input  logic              reset,
   input  logic [5:0]        ch_append,
   input  logic [7:0]        cmd,
   input  logic [3:0]        rd_row,
   input  logic [COL_W-1:0]  rd_col,
   output logic [5:0]        rd_code,
   output logic [COL_W-1:0]  cur_col,
   output logic [LINE_W-1:0] cur_line,
   output logic              busy,
   output logic              ready,
   output logic              overflow
);

   localparam int CELLS  = HIST_LINES * COLS;
   localparam int ADDR_W = LINE_W + COL_W;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [5:0] CODE_NULL = 6'd0;
   localparam logic [5:0] CODE_NONE = 6'd63;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_CLEAR
   } state_t;

   typedef enum logic [2:0] {
      EV_CHAR,
      EV_BS,
      EV_BREAK,
      EV_PGUP,
      EV_PGDN
   } ev_kind_t;

   typedef struct packed {
      ev_kind_t   kind;
      logic [5:0] code;
   } term_ev_t;

   state_t            state;
   logic [ADDR_W-1:0] wipe_cnt;
   logic [COL_W-1:0]  clr_cnt;
   logic [LINE_W-1:0] offset;
   logic [LINE_W:0]   lines_used;

   logic [4:1]        cmd_q;
   logic [4:1]        cmd_rise;
   logic              unused_cmd_bits;

   term_ev_t          cand [5];
   logic [4:0]        cand_v;
   term_ev_t          push0;
   term_ev_t          push1;
   logic              push0_v;
   logic              push1_v;
   logic              extra_lost;

   term_ev_t          fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic [CNT_W:0]    cnt_after0;
   logic              acc0;
   logic              acc1;
   logic              lost;
   logic              pop;
   term_ev_t          head;

   logic [5:0]        mem [CELLS];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [5:0]        mem_wdata;
   logic [LINE_W-1:0] view_line;
   logic [ADDR_W-1:0] rd_addr;

   logic [LINE_W:0]   scroll_lim;
   logic              offset_room;

   assign unused_cmd_bits = ^cmd[7:5];
   assign cmd_rise        = cmd[4:1] & ~cmd_q;

   // Candidate events in their queueing order: breakline, backspace, pgup,
   // pgdown, then the character.
   always_comb begin
      cand[0] = '{kind: EV_BREAK, code: CODE_NULL};
      cand[1] = '{kind: EV_BS,    code: CODE_NULL};
      cand[2] = '{kind: EV_PGUP,  code: CODE_NULL};
      cand[3] = '{kind: EV_PGDN,  code: CODE_NULL};
      cand[4] = '{kind: EV_CHAR,  code: ch_append};
      cand_v  = {(ch_append != CODE_NULL) && (ch_append != CODE_NONE),
                 cmd_rise[2], cmd_rise[1], cmd_rise[3], cmd_rise[4]};
   end

   // Pick the first two candidates for the two FIFO write slots. A third or
   // later event in the same cycle has no slot and counts as lost.
   always_comb begin
      push0      = cand[0];
      push1      = cand[0];
      push0_v    = 1'b0;
      push1_v    = 1'b0;
      extra_lost = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (cand_v[i]) begin
            if (!push0_v) begin
               push0_v = 1'b1;
               push0   = cand[i];
            end else if (!push1_v) begin
               push1_v = 1'b1;
               push1   = cand[i];
            end else begin
               extra_lost = 1'b1;
            end
         end
      end
   end

   // Fullness is judged on the occupancy at the start of the cycle, so a pop
   // in the same cycle does not make room for a push.
   always_comb begin
      acc0       = push0_v && (fifo_cnt != CNT_W'(FIFO_DEPTH));
      cnt_after0 = {1'b0, fifo_cnt} + (CNT_W + 1)'(acc0);
      acc1       = push1_v && (cnt_after0 < (CNT_W + 1)'(FIFO_DEPTH));
      lost       = (push0_v && !acc0) || (push1_v && !acc1) || extra_lost;
      pop        = (state == ST_IDLE) && (fifo_cnt != '0);
      head       = fifo_mem[rd_ptr];
   end

   // Event FIFO storage; up to two entries written per cycle.
   always_ff @(posedge clk_25mhz) begin
      if (acc0) begin
         fifo_mem[wr_ptr] <= push0;
      end
      if (acc1) begin
         fifo_mem[wr_ptr + PTR_W'(acc0)] <= push1;
      end
   end

   // FIFO pointers, sticky overflow, command edge history and busy.
   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         overflow <= 1'b0;
         cmd_q    <= '0;
         busy     <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + PTR_W'(acc0) + PTR_W'(acc1);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         fifo_cnt <= fifo_cnt + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);
         if (lost) begin
            overflow <= 1'b1;
         end
         cmd_q    <= cmd[4:1];
         busy     <= cmd[0];
      end
   end

   // Page-up limit: the oldest kept line may reach the top row, never further.
   always_comb begin
      scroll_lim  = (lines_used > (LINE_W + 1)'(ROWS)) ?
                    lines_used - (LINE_W + 1)'(ROWS) : '0;
      offset_room = ({1'b0, offset} < scroll_lim);
   end

   // Single memory write port: wipe during INIT, line wipe during CLEAR,
   // otherwise the character or backspace being applied this cycle.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = CODE_NULL;
      if (reset) begin
         case (state)
            ST_INIT: begin
               mem_we    = 1'b1;
               mem_waddr = wipe_cnt;
            end
            ST_CLEAR: begin
               mem_we    = 1'b1;
               mem_waddr = {cur_line, clr_cnt};
            end
            ST_IDLE: begin
               if (pop) begin
                  case (head.kind)
                     EV_CHAR: begin
                        mem_we    = 1'b1;
                        mem_waddr = {cur_line, cur_col};
                        mem_wdata = head.code;
                     end
                     EV_BS: begin
                        if (cur_col != '0) begin
                           mem_we    = 1'b1;
                           mem_waddr = {cur_line, cur_col - COL_W'(1)};
                        end
                     end
                     default: begin
                     end
                  endcase
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // The top visible row sits ROWS-1 lines above the cursor, pushed further
   // back by the page-up offset; the ring arithmetic wraps naturally.
   always_comb begin
      view_line = cur_line - LINE_W'(ROWS - 1) - offset + LINE_W'(rd_row);
      rd_addr   = {view_line, rd_col};
   end

   // Registered read; a same-cycle write to the same cell returns old data.
   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         rd_code <= CODE_NULL;
      end else if (!ready) begin
         rd_code <= CODE_NULL;
      end else begin
         rd_code <= mem[rd_addr];
      end
   end

   // Control FSM: power-up wipe, event application and line clearing.
   always_ff @(posedge clk_25mhz) begin
      if (!reset) begin
         state      <= ST_INIT;
         wipe_cnt   <= '0;
         clr_cnt    <= '0;
         cur_col    <= '0;
         cur_line   <= '0;
         offset     <= '0;
         lines_used <= (LINE_W + 1)'(1);
         ready      <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               wipe_cnt <= wipe_cnt + ADDR_W'(1);
               if (wipe_cnt == ADDR_W'(CELLS - 1)) begin
                  state <= ST_IDLE;
                  ready <= 1'b1;
               end
            end

            ST_CLEAR: begin
               clr_cnt <= clr_cnt + COL_W'(1);
               if (clr_cnt == COL_W'(COLS - 1)) begin
                  state <= ST_IDLE;
               end
            end

            ST_IDLE: begin
               if (pop) begin
                  case (head.kind)
                     EV_CHAR: begin
                        offset <= '0;
                        if (cur_col == COL_W'(COLS - 1)) begin
`ifdef TERM_AUTOWRAP_EN
                           cur_col  <= '0;
                           cur_line <= cur_line + LINE_W'(1);
                           if (lines_used != (LINE_W + 1)'(HIST_LINES)) begin
                              lines_used <= lines_used + (LINE_W + 1)'(1);
                           end
                           clr_cnt  <= '0;
                           state    <= ST_CLEAR;
`else
                           cur_col  <= cur_col;
`endif
                        end else begin
                           cur_col <= cur_col + COL_W'(1);
                        end
                     end

                     EV_BS: begin
                        offset <= '0;
                        if (cur_col != '0) begin
                           cur_col <= cur_col - COL_W'(1);
                        end
                     end

                     EV_BREAK: begin
                        offset   <= '0;
                        cur_col  <= '0;
                        cur_line <= cur_line + LINE_W'(1);
                        if (lines_used != (LINE_W + 1)'(HIST_LINES)) begin
                           lines_used <= lines_used + (LINE_W + 1)'(1);
                        end
                        clr_cnt  <= '0;
                        state    <= ST_CLEAR;
                     end

                     EV_PGUP: begin
                        if (offset_room) begin
                           offset <= offset + LINE_W'(1);
                        end
                     end

                     EV_PGDN: begin
                        if (offset != '0) begin
                           offset <= offset - LINE_W'(1);
                        end
                     end

                     default: begin
                     end
                  endcase
               end
            end

            default: begin
               state <= ST_INIT;
            end
         endcase
      end
   end

endmodule
